// File: rtl/board_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
// Cell, result and FSM encodings plus the eight winning lines in win_line bit order.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        PLAYING = 2'b00,
        X_WIN   = 2'b01,
        O_WIN   = 2'b10,
        DRAW    = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        SEEK  = 2'b10,
        OVER  = 2'b11
    } fsm_state_t;

    // Index [7] is the anti-diagonal, [0] is the top row.
    localparam logic [7:0][2:0][3:0] WIN_LINES = {
        4'd2, 4'd4, 4'd6,
        4'd0, 4'd4, 4'd8,
        4'd2, 4'd5, 4'd8,
        4'd1, 4'd4, 4'd7,
        4'd0, 4'd3, 4'd6,
        4'd6, 4'd7, 4'd8,
        4'd3, 4'd4, 4'd5,
        4'd0, 4'd1, 4'd2
    };

    function automatic cell_t cell_at(input logic [17:0] cells, input logic [3:0] idx);
        return cell_t'(cells[{idx, 1'b0} +: 2]);
    endfunction

endpackage

// File: rtl/board_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debouncer and rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [1:0]    sync_reg;
    logic          level_reg;
    logic [CW-1:0] count_reg;
    logic          press_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            level_reg <= 1'b0;
            count_reg <= '0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            press_reg <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the stability count.
            if (sync_reg[1] != level_reg) begin
                if (count_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_reg <= sync_reg[1];
                    count_reg <= '0;
                    press_reg <= sync_reg[1];
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/board_ctrl.sv
// Tic-tac-toe game-state controller feeding the VGA renderer.
// Define BOARD_FRAME_SYNC_EN to update the renderer-facing outputs only on frame_tick.
module board_ctrl
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_sel,
    input  logic        frame_tick,
    output logic [17:0] cell_state,
    output logic [3:0]  cursor,
    output logic        turn,
    output logic [1:0]  game_state,
    output logic [7:0]  win_line,
    output logic        busy
);
    logic next_press;
    logic sel_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .press (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_sel),
        .press (sel_press)
    );

    fsm_state_t  state_reg, state_next;
    logic [17:0] cells_reg, cells_next;
    logic [3:0]  cursor_reg, cursor_next;
    logic [3:0]  moves_reg, moves_next;
    logic [3:0]  steps_reg, steps_next;
    logic        turn_reg, turn_next;
    game_state_t gstate_reg, gstate_next;
    logic [7:0]  win_reg, win_next;
    logic        busy_reg;

    cell_t       mark;
    logic [3:0]  cursor_inc;
    logic [7:0]  line_hit;

    assign mark       = turn_reg ? MARK_O : MARK_X;
    assign cursor_inc = (cursor_reg == 4'd8) ? 4'd0 : cursor_reg + 4'd1;

    for (genvar gi = 0; gi < 8; gi++) begin : g_line
        assign line_hit[gi] = (cell_at(cells_reg, WIN_LINES[gi][0]) == mark) &&
                              (cell_at(cells_reg, WIN_LINES[gi][1]) == mark) &&
                              (cell_at(cells_reg, WIN_LINES[gi][2]) == mark);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= PLAY;
            cells_reg  <= '0;
            cursor_reg <= '0;
            moves_reg  <= '0;
            steps_reg  <= '0;
            turn_reg   <= 1'b0;
            gstate_reg <= PLAYING;
            win_reg    <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cells_reg  <= cells_next;
            cursor_reg <= cursor_next;
            moves_reg  <= moves_next;
            steps_reg  <= steps_next;
            turn_reg   <= turn_next;
            gstate_reg <= gstate_next;
            win_reg    <= win_next;
            busy_reg   <= (state_next == CHECK) || (state_next == SEEK);
        end
    end

    always_comb begin
        state_next  = state_reg;
        cells_next  = cells_reg;
        cursor_next = cursor_reg;
        moves_next  = moves_reg;
        steps_next  = steps_reg;
        turn_next   = turn_reg;
        gstate_next = gstate_reg;
        win_next    = win_reg;
        case (state_reg)
            PLAY: begin
                // Sel wins a same-cycle collision; the next pulse is simply lost.
                if (sel_press) begin
                    if (cell_at(cells_reg, cursor_reg) == EMPTY) begin
                        cells_next[{cursor_reg, 1'b0} +: 2] = mark;
                        moves_next = (moves_reg == 4'd9) ? 4'd9 : moves_reg + 4'd1;
                        state_next = CHECK;
                    end
                end else if (next_press) begin
                    steps_next = 4'd0;
                    state_next = SEEK;
                end
            end
            CHECK: begin
                if (|line_hit) begin
                    win_next    = line_hit;
                    gstate_next = turn_reg ? O_WIN : X_WIN;
                    state_next  = OVER;
                end else if (moves_reg == 4'd9) begin
                    gstate_next = DRAW;
                    state_next  = OVER;
                end else begin
                    turn_next  = ~turn_reg;
                    steps_next = 4'd0;
                    state_next = SEEK;
                end
            end
            SEEK: begin
                cursor_next = cursor_inc;
                steps_next  = steps_reg + 4'd1;
                if ((cell_at(cells_reg, cursor_inc) == EMPTY) || (steps_reg == 4'd8)) begin
                    state_next = PLAY;
                end
            end
            OVER: begin
                if (sel_press) begin
                    cells_next  = '0;
                    cursor_next = 4'd0;
                    moves_next  = 4'd0;
                    turn_next   = 1'b0;
                    gstate_next = PLAYING;
                    win_next    = '0;
                    state_next  = PLAY;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    logic load;
`ifdef BOARD_FRAME_SYNC_EN
    assign load = frame_tick;
`else
    logic frame_tick_unused;
    assign frame_tick_unused = frame_tick;
    assign load = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_state <= '0;
            cursor     <= '0;
            turn       <= 1'b0;
            game_state <= '0;
            win_line   <= '0;
        end else if (load) begin
            cell_state <= cells_reg;
            cursor     <= cursor_reg;
            turn       <= turn_reg;
            game_state <= gstate_reg;
            win_line   <= win_reg;
        end
    end

    assign busy = busy_reg;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed self-checking bench for board_ctrl with DEBOUNCE_CYCLES = 4.
// Define BOARD_FRAME_SYNC_EN here as well to exercise the shadowed outputs.
module tb_board_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_sel = 1'b0;
    logic        frame_tick = 1'b0;
    logic [17:0] cell_state;
    logic [3:0]  cursor;
    logic        turn;
    logic [1:0]  game_state;
    logic [7:0]  win_line;
    logic        busy;

    int checks = 0;
    int passed = 0;
    logic hold_ticks = 1'b0;
    logic force_tick = 1'b0;

    board_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_sel    (btn_sel),
        .frame_tick (frame_tick),
        .cell_state (cell_state),
        .cursor     (cursor),
        .turn       (turn),
        .game_state (game_state),
        .win_line   (win_line),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            cnt++;
            frame_tick = force_tick || (!hold_ticks && (cnt % 16 == 0));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_timeout busy=%b required 0", busy);
        else passed++;
        repeat (20) @(negedge clk);
    endtask

    task automatic press(input logic use_next, input logic use_sel, input int sel_delay);
        @(negedge clk);
        btn_next = use_next;
        if (use_sel && sel_delay == 0) btn_sel = 1'b1;
        repeat (sel_delay) @(negedge clk);
        if (use_sel) btn_sel = 1'b1;
        repeat (12) @(negedge clk);
        btn_next = 1'b0;
        btn_sel  = 1'b0;
        repeat (12) @(negedge clk);
        wait_idle();
    endtask

    task automatic move_to(input logic [3:0] target);
        int n = 0;
        while (cursor !== target && n < 9) begin
            press(1'b1, 1'b0, 0);
            n++;
        end
        checks++;
        if (cursor !== target) $display("FAIL move_to cursor=%0d required %0d", cursor, target);
        else passed++;
    endtask

    task automatic place(input logic [3:0] target);
        move_to(target);
        press(1'b0, 1'b1, 0);
        $display("placed at cell %0d: cell_state=%h cursor=%0d turn=%b game_state=%b",
                 target, cell_state, cursor, turn, game_state);
    endtask

    task automatic test_reset();
        do_reset();
        repeat (20) @(negedge clk);
        checks += 6;
        if (cell_state !== 18'h0) $display("FAIL reset_cells got=%h required 0", cell_state); else passed++;
        if (cursor !== 4'd0) $display("FAIL reset_cursor got=%0d required 0", cursor); else passed++;
        if (turn !== 1'b0) $display("FAIL reset_turn got=%b required 0", turn); else passed++;
        if (game_state !== 2'b00) $display("FAIL reset_game_state got=%b required 00", game_state); else passed++;
        if (win_line !== 8'h00) $display("FAIL reset_win_line got=%b required 0", win_line); else passed++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b required 0", busy); else passed++;
        $display("reset: cell_state=%h cursor=%0d busy=%b", cell_state, cursor, busy);
    endtask

    task automatic test_debounce();
        do_reset();
        @(negedge clk); btn_next = 1'b1;
        @(negedge clk); btn_next = 1'b0;
        @(negedge clk); btn_next = 1'b1;
        @(negedge clk); btn_next = 1'b0;
        @(negedge clk); btn_next = 1'b1;
        repeat (14) @(negedge clk);
        btn_next = 1'b0;
        repeat (14) @(negedge clk);
        wait_idle();
        checks += 2;
        if (cursor !== 4'd1) $display("FAIL debounce_cursor got=%0d required 1", cursor); else passed++;
        if (cell_state !== 18'h0) $display("FAIL debounce_cells got=%h required 0", cell_state); else passed++;
        $display("debounce: cursor=%0d", cursor);
    endtask

    task automatic test_win();
        logic [17:0] exp_cells;
        do_reset();
        place(4'd0);
        checks += 3;
        if (cell_state !== 18'h1) $display("FAIL first_mark_cells got=%h required 00001", cell_state); else passed++;
        if (cursor !== 4'd1) $display("FAIL first_mark_seek got=%0d required 1", cursor); else passed++;
        if (turn !== 1'b1) $display("FAIL first_mark_turn got=%b required 1", turn); else passed++;
        place(4'd3);
        checks++;
        if (cursor !== 4'd4) $display("FAIL o3_seek got=%0d required 4", cursor); else passed++;
        place(4'd1);
        place(4'd4);
        place(4'd2);
        exp_cells = {8'b0, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
        checks += 5;
        if (cell_state !== exp_cells) $display("FAIL win_cells got=%h required %h", cell_state, exp_cells); else passed++;
        if (game_state !== 2'b01) $display("FAIL win_game_state got=%b required 01", game_state); else passed++;
        if (win_line !== 8'b0000_0001) $display("FAIL win_line got=%b required 00000001", win_line); else passed++;
        if (turn !== 1'b0) $display("FAIL win_turn got=%b required 0", turn); else passed++;
        if (cursor !== 4'd2) $display("FAIL win_cursor got=%0d required 2", cursor); else passed++;
        press(1'b1, 1'b0, 0);
        checks++;
        if (cursor !== 4'd2) $display("FAIL over_next_ignored cursor=%0d required 2", cursor); else passed++;
        press(1'b0, 1'b1, 0);
        checks += 4;
        if (cell_state !== 18'h0) $display("FAIL restart_cells got=%h required 0", cell_state); else passed++;
        if (game_state !== 2'b00) $display("FAIL restart_game_state got=%b required 00", game_state); else passed++;
        if (win_line !== 8'h00) $display("FAIL restart_win_line got=%b required 0", win_line); else passed++;
        if (cursor !== 4'd0) $display("FAIL restart_cursor got=%0d required 0", cursor); else passed++;
    endtask

    task automatic test_draw();
        logic [17:0] exp_cells;
        do_reset();
        place(4'd0); place(4'd1); place(4'd2); place(4'd4); place(4'd3);
        place(4'd6); place(4'd7); place(4'd8);
        checks++;
        if (game_state !== 2'b00) $display("FAIL pre_draw_state got=%b required 00", game_state); else passed++;
        place(4'd5);
        exp_cells = {2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
        checks += 3;
        if (cell_state !== exp_cells) $display("FAIL draw_cells got=%h required %h", cell_state, exp_cells); else passed++;
        if (game_state !== 2'b11) $display("FAIL draw_game_state got=%b required 11", game_state); else passed++;
        if (win_line !== 8'h00) $display("FAIL draw_win_line got=%b required 0", win_line); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(1'b1, 1'b1, 0);
        checks += 3;
        if (cell_state !== 18'h1) $display("FAIL same_cycle_cells got=%h required 00001", cell_state); else passed++;
        if (cursor !== 4'd1) $display("FAIL same_cycle_cursor got=%0d required 1", cursor); else passed++;
        if (turn !== 1'b1) $display("FAIL same_cycle_turn got=%b required 1", turn); else passed++;
        press(1'b1, 1'b1, 1);
        checks += 3;
        if (cell_state !== 18'h1) $display("FAIL busy_sel_cells got=%h required 00001", cell_state); else passed++;
        if (cursor !== 4'd2) $display("FAIL busy_sel_cursor got=%0d required 2", cursor); else passed++;
        if (turn !== 1'b1) $display("FAIL busy_sel_turn got=%b required 1", turn); else passed++;
    endtask

`ifdef BOARD_FRAME_SYNC_EN
    task automatic test_frame_sync();
        do_reset();
        hold_ticks = 1'b1;
        repeat (3) @(negedge clk);
        press(1'b0, 1'b1, 0);
        checks += 2;
        if (cell_state !== 18'h0) $display("FAIL sync_hold_cells got=%h required 0", cell_state); else passed++;
        if (cursor !== 4'd0) $display("FAIL sync_hold_cursor got=%0d required 0", cursor); else passed++;
        force_tick = 1'b1;
        @(negedge clk);
        force_tick = 1'b0;
        @(negedge clk);
        checks += 3;
        if (cell_state !== 18'h1) $display("FAIL sync_load_cells got=%h required 00001", cell_state); else passed++;
        if (cursor !== 4'd1) $display("FAIL sync_load_cursor got=%0d required 1", cursor); else passed++;
        if (turn !== 1'b1) $display("FAIL sync_load_turn got=%b required 1", turn); else passed++;
        hold_ticks = 1'b0;
        $display("frame sync: cell_state=%h cursor=%0d", cell_state, cursor);
    endtask
`endif

    initial begin
        test_reset();
        test_debounce();
        test_win();
        test_draw();
        test_back_to_back();
`ifdef BOARD_FRAME_SYNC_EN
        test_frame_sync();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
